// File: rtl/vocab_matcher.sv
// -----------------------------------------------------------------------------
// vocab_matcher
// Writable vocabulary of 2**ADDR_WIDTH fixed-width, NUL-padded words with a
// ready/valid lookup port. Each lookup scans an inclusive, optionally wrapping
// address range at one entry per cycle. It runs in exact-match or
// longest-prefix mode.
//
// Ports
//   clk, rst_n        clock / asynchronous active-low reset
//   wr_en/addr/data   vocabulary write; committed only while idle (wr_ready)
//   in_valid/ready    request handshake; in_word, in_prefix_mode,
//                     start_addr and end_addr are sampled at acceptance
//   out_valid/ready   result handshake; result fields are held while valid
//   out_found         a match was found
//   out_index         matching entry, or the last examined entry on a miss
//   out_len           matched length in characters (0 on a miss)
//   out_null_hit      scan stopped on a null entry
//   out_wrapped       scan address stepped from all-ones to zero
// -----------------------------------------------------------------------------
module vocab_matcher #(
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    WORD_LENGTH = 3,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] NULL_CHAR   = 8'h00,
    localparam int                   LEN_W       = $clog2(WORD_LENGTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] wr_data,
    output logic                              wr_ready,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] in_word,
    input  logic                              in_prefix_mode,
    input  logic [ADDR_WIDTH-1:0]             start_addr,
    input  logic [ADDR_WIDTH-1:0]             end_addr,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_found,
    output logic [ADDR_WIDTH-1:0]             out_index,
    output logic [LEN_W-1:0]                  out_len,
    output logic                              out_null_hit,
    output logic                              out_wrapped
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int WW    = WORD_LENGTH * DATA_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

    // Character 0 sits in the MSBs of a word.
    function automatic logic [DATA_WIDTH-1:0] f_char(input logic [WW-1:0] w, input int i);
        return w[(WORD_LENGTH-1-i)*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    // Number of leading non-null characters.
    function automatic logic [LEN_W-1:0] f_len(input logic [WW-1:0] w);
        logic [LEN_W-1:0] len;
        logic             run;
        len = '0;
        run = 1'b1;
        for (int i = 0; i < WORD_LENGTH; i++) begin
            if (run && (f_char(w, i) != NULL_CHAR)) len = LEN_W'(i + 1);
            else                                    run = 1'b0;
        end
        return len;
    endfunction

    // First len characters of both words agree.
    function automatic logic f_prefix_eq(input logic [WW-1:0] e, input logic [WW-1:0] w,
                                         input logic [LEN_W-1:0] len);
        logic eq;
        eq = 1'b1;
        for (int i = 0; i < WORD_LENGTH; i++) begin
            if ((LEN_W'(i) < len) && (f_char(e, i) != f_char(w, i))) eq = 1'b0;
        end
        return eq;
    endfunction

    state_t                r_state, w_state_next;
    logic [WW-1:0]         r_mem [DEPTH];
    logic [WW-1:0]         r_word;
    logic                  r_prefix;
    logic [ADDR_WIDTH-1:0] r_addr, r_end;
    logic [LEN_W-1:0]      r_best_len;
    logic [ADDR_WIDTH-1:0] r_best_idx;
    logic                  r_wrapped;

    logic                  r_out_found, r_out_null_hit, r_out_wrapped;
    logic [ADDR_WIDTH-1:0] r_out_index;
    logic [LEN_W-1:0]      r_out_len;

    logic [WW-1:0]         w_entry;
    logic [LEN_W-1:0]      w_entry_len, w_word_len;
    logic                  w_is_null, w_exact, w_better, w_last;
    logic [LEN_W-1:0]      w_best_len_next;
    logic [ADDR_WIDTH-1:0] w_best_idx_next;
    logic                  w_stop, w_res_found, w_res_null;
    logic [ADDR_WIDTH-1:0] w_res_index;
    logic [LEN_W-1:0]      w_res_len;

    assign w_entry     = r_mem[r_addr];
    assign w_entry_len = f_len(w_entry);
    assign w_word_len  = f_len(r_word);
    assign w_is_null   = (f_char(w_entry, 0) == NULL_CHAR);
    assign w_exact     = (w_entry == r_word);
    assign w_last      = (r_addr == r_end);
    // Strictly longer than the best so far, so ties keep the first-scanned entry.
    assign w_better    = r_prefix && (w_entry_len != '0) &&
                         f_prefix_eq(w_entry, r_word, w_entry_len) &&
                         (w_entry_len > r_best_len);
    assign w_best_len_next = w_better ? w_entry_len : r_best_len;
    assign w_best_idx_next = w_better ? r_addr      : r_best_idx;

    always_comb begin
        w_state_next = r_state;
        w_stop       = 1'b0;
        w_res_found  = 1'b0;
        w_res_index  = r_addr;
        w_res_len    = '0;
        w_res_null   = 1'b0;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_next = ST_SCAN;
            ST_SCAN: begin
                if (w_is_null) begin
                    // A held prefix candidate still counts as a match.
                    w_stop     = 1'b1;
                    w_res_null = 1'b1;
                    if (r_best_len != '0) begin
                        w_res_found = 1'b1;
                        w_res_index = r_best_idx;
                        w_res_len   = r_best_len;
                    end
                end else if (!r_prefix && w_exact) begin
                    w_stop      = 1'b1;
                    w_res_found = 1'b1;
                    w_res_len   = w_word_len;
                end else if (w_better && (w_entry_len == LEN_W'(WORD_LENGTH))) begin
                    w_stop      = 1'b1;
                    w_res_found = 1'b1;
                    w_res_len   = w_entry_len;
                end else if (w_last) begin
                    w_stop = 1'b1;
                    if (w_best_len_next != '0) begin
                        w_res_found = 1'b1;
                        w_res_index = w_best_idx_next;
                        w_res_len   = w_best_len_next;
                    end
                end
                if (w_stop) w_state_next = ST_DONE;
            end
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= {WORD_LENGTH{NULL_CHAR}};
        end else if ((r_state == ST_IDLE) && wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_word         <= '0;
            r_prefix       <= 1'b0;
            r_addr         <= '0;
            r_end          <= '0;
            r_best_len     <= '0;
            r_best_idx     <= '0;
            r_wrapped      <= 1'b0;
            r_out_found    <= 1'b0;
            r_out_index    <= '0;
            r_out_len      <= '0;
            r_out_null_hit <= 1'b0;
            r_out_wrapped  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_word     <= in_word;
                        r_prefix   <= in_prefix_mode;
                        r_addr     <= start_addr;
                        r_end      <= end_addr;
                        r_best_len <= '0;
                        r_best_idx <= '0;
                        r_wrapped  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (w_stop) begin
                        r_out_found    <= w_res_found;
                        r_out_index    <= w_res_index;
                        r_out_len      <= w_res_len;
                        r_out_null_hit <= w_res_null;
                        r_out_wrapped  <= r_wrapped;
                    end else begin
                        r_addr     <= r_addr + ADDR_WIDTH'(1);
                        r_best_len <= w_best_len_next;
                        r_best_idx <= w_best_idx_next;
                        if (&r_addr) r_wrapped <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (r_state == ST_IDLE);
    assign wr_ready     = (r_state == ST_IDLE);
    assign out_valid    = (r_state == ST_DONE);
    assign out_found    = r_out_found;
    assign out_index    = r_out_index;
    assign out_len      = r_out_len;
    assign out_null_hit = r_out_null_hit;
    assign out_wrapped  = r_out_wrapped;

endmodule

// File: tb/tb_vocab_matcher.sv
// -----------------------------------------------------------------------------
// tb_vocab_matcher
// Directed scenarios followed by randomized lookups. The driver computes the
// expected result from a reference vocabulary model at acceptance and queues
// it; an independent monitor pops and checks each result as the DUT presents
// it, applies randomized out_ready backpressure and checks latency.
// -----------------------------------------------------------------------------
module tb_vocab_matcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        wr_ready;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_word = '0;
    logic        in_prefix_mode = 1'b0;
    logic [3:0]  start_addr = '0;
    logic [3:0]  end_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_found;
    logic [3:0]  out_index;
    logic [1:0]  out_len;
    logic        out_null_hit;
    logic        out_wrapped;

    vocab_matcher #(.ADDR_WIDTH(4), .WORD_LENGTH(3), .DATA_WIDTH(8), .NULL_CHAR(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .in_prefix_mode(in_prefix_mode), .start_addr(start_addr), .end_addr(end_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_found(out_found),
        .out_index(out_index), .out_len(out_len), .out_null_hit(out_null_hit),
        .out_wrapped(out_wrapped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic found;
        logic [3:0] idx;
        logic [1:0] len;
        logic null_hit;
        logic wrapped;
        int   n;
        int   acc;
        int   hold;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] mm [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: strings are 3 bytes, character 0 in the MSBs.
    function automatic int slen(input logic [23:0] w);
        int n = 0;
        for (int i = 0; i < 3; i++) begin
            if (w[23-8*i -: 8] == 8'h00) break;
            n++;
        end
        return n;
    endfunction

    function automatic bit same_prefix(input logic [23:0] a, input logic [23:0] b, input int l);
        return (a >> (8 * (3 - l))) == (b >> (8 * (3 - l)));
    endfunction

    function automatic exp_t model(input logic [23:0] w, input bit pm, input int s, input int e);
        exp_t        r;
        int          order[$];
        int          a;
        int          best_len;
        int          best_idx;
        int          l;
        logic [23:0] ent;
        r.found = 0; r.idx = 0; r.len = 0; r.null_hit = 0; r.wrapped = 0;
        r.n = 0; r.acc = 0; r.hold = 0;
        a = s;
        order.push_back(a);
        while (a != e) begin
            a = (a + 1) % 16;
            order.push_back(a);
        end
        best_len = 0;
        best_idx = 0;
        foreach (order[k]) begin
            ent   = mm[order[k]];
            r.n   = k + 1;
            r.idx = 4'(order[k]);
            if (k > 0 && order[k] == 0) r.wrapped = 1;
            if (ent[23:16] == 8'h00) begin
                r.null_hit = 1;
                if (best_len > 0) begin
                    r.found = 1; r.idx = 4'(best_idx); r.len = 2'(best_len);
                end
                return r;
            end
            if (!pm) begin
                if (ent == w) begin
                    r.found = 1; r.len = 2'(slen(w));
                    return r;
                end
            end else begin
                l = slen(ent);
                if (l > 0 && l > best_len && same_prefix(ent, w, l)) begin
                    best_len = l;
                    best_idx = order[k];
                    if (l == 3) begin
                        r.found = 1; r.len = 2'd3;
                        return r;
                    end
                end
            end
        end
        if (best_len > 0) begin
            r.found = 1; r.idx = 4'(best_idx); r.len = 2'(best_len);
        end
        return r;
    endfunction

    task automatic wait_idle(input string name);
        int t = 0;
        @(negedge clk);
        while (!(in_ready && wr_ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check(name, 32'd0, 32'd1);
    endtask

    task automatic wr(input int a, input logic [23:0] d);
        wait_idle("wr_idle_timeout");
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
        mm[a] = d;
    endtask

    task automatic req(input logic [23:0] w, input bit pm, input int s, input int e,
                       input int hold, input bit expect_it);
        exp_t x;
        wait_idle("req_idle_timeout");
        x = model(w, pm, s, e);
        in_valid       = 1'b1;
        in_word        = w;
        in_prefix_mode = pm;
        start_addr     = 4'(s);
        end_addr       = 4'(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        x.acc  = cyc;
        x.hold = hold;
        if (expect_it) sb.push_back(x);
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) check("drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    function automatic logic [23:0] rand_word(input int minlen);
        logic [23:0] w = '0;
        int          l = int'($urandom_range(3, minlen));
        for (int i = 0; i < l; i++) w[23-8*i -: 8] = ($urandom_range(1, 0) == 1) ? 8'h61 : 8'h62;
        if (l < 3 && $urandom_range(7, 0) == 0) w[7:0] = 8'h61;
        return w;
    endfunction

    // Monitor: pops one expectation per presented result and holds out_ready
    // low for that result's hold count, checking the outputs stay put.
    initial begin : monitor
        bit   active;
        bit   releasing;
        int   hold;
        exp_t cur;
        active = 0; releasing = 0; hold = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0; releasing = 0; out_ready = 1'b0;
            end else if (releasing) begin
                check("valid_drop", 32'(out_valid), 32'd0);
                releasing = 0; active = 0; out_ready = 1'b0;
            end else if (out_valid) begin
                if (!active) begin
                    if (sb.size() == 0) begin
                        check("unexpected_valid", 32'd1, 32'd0);
                        out_ready = 1'b1;
                        releasing = 1;
                    end else begin
                        cur    = sb.pop_front();
                        active = 1;
                        hold   = cur.hold;
                        check("latency", 32'(cyc - cur.acc), 32'(cur.n));
                        $display("txn: found=%0d index=%0d len=%0d null_hit=%0d wrapped=%0d latency=%0d",
                                 out_found, out_index, out_len, out_null_hit, out_wrapped, cyc - cur.acc);
                    end
                end
                if (active) begin
                    check("found",    32'(out_found),    32'(cur.found));
                    check("index",    32'(out_index),    32'(cur.idx));
                    check("len",      32'(out_len),      32'(cur.len));
                    check("null_hit", 32'(out_null_hit), 32'(cur.null_hit));
                    check("wrapped",  32'(out_wrapped),  32'(cur.wrapped));
                    check("in_ready_busy", 32'(in_ready), 32'd0);
                    check("wr_ready_busy", 32'(wr_ready), 32'd0);
                    if (hold == 0) begin
                        out_ready = 1'b1;
                        releasing = 1;
                    end else begin
                        hold--;
                    end
                end
            end
        end
    end

    initial begin : driver
        int t;
        for (int i = 0; i < 16; i++) mm[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_found",     32'(out_found), 32'd0);
        check("rst_index",     32'(out_index), 32'd0);
        check("rst_len",       32'(out_len), 32'd0);
        check("rst_null_hit",  32'(out_null_hit), 32'd0);
        check("rst_wrapped",   32'(out_wrapped), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);

        // Exact hit
        wr(0, "Hel"); wr(1, "abc"); wr(2, "xyz");
        req("abc", 1'b0, 0, 15, 0, 1'b1);
        drain();
        // Longest prefix
        wr(4, {8'h48, 8'h00, 8'h00}); wr(5, {8'h48, 8'h65, 8'h00}); wr(6, "Hex");
        req("Hel", 1'b1, 4, 6, 1, 1'b1);
        drain();
        // Null stop
        req("qqq", 1'b0, 0, 15, 0, 1'b1);
        drain();
        // Wrap
        wr(14, "aaa"); wr(15, "bbb");
        req("Hel", 1'b0, 14, 1, 2, 1'b1);
        drain();

        // Backpressure with a write attempted while busy (must be dropped)
        req("abc", 1'b0, 0, 15, 5, 1'b1);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = "zzz";
        @(negedge clk);
        wr_en = 1'b0;
        drain();
        req("abc", 1'b0, 0, 15, 0, 1'b1);
        drain();

        // Reset during a long scan
        for (int a = 0; a < 16; a++) wr(a, {8'h6B, 8'(8'h61 + a), 8'h6D});
        req("zzz", 1'b0, 0, 15, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 16; i++) mm[i] = '0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_outputs",   32'({out_found, out_index, out_len, out_null_hit, out_wrapped}), 32'd0);
        check("abort_in_ready",  32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        req("Hel", 1'b0, 7, 3, 0, 1'b1);
        drain();

        // Randomized phase
        for (int a = 0; a < 16; a++) wr(a, ($urandom_range(5, 0) == 0) ? 24'h0 : rand_word(1));
        for (int k = 0; k < 40; k++) begin
            for (int j = 0; j < int'($urandom_range(2, 0)); j++)
                wr(int'($urandom_range(15, 0)), ($urandom_range(7, 0) == 0) ? 24'h0 : rand_word(1));
            req(rand_word(0), 1'($urandom_range(1, 0)), int'($urandom_range(15, 0)),
                int'($urandom_range(15, 0)), int'($urandom_range(2, 0)), 1'b1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
